// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the clock-enable generator.
//   state_e : top-level sequencing state (2 bits)
//   ch_w()  : channel-select width, never narrower than 1 bit
//   clamp() : min(phase, div), evaluated at CLAMP_W bits
package clk_en_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Working width for clamp(); divider fields up to 32 bits are supported.
  localparam int unsigned CLAMP_W = 32;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // A phase beyond the period would never be reached, so it is pinned to div.
  function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] phase,
                                               input logic [CLAMP_W-1:0] div);
    return (phase > div) ? div : phase;
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: divider/phase/pending registers, down-counter
// and registered ce.
//   refclk, reset_n : clock, synchronous active-low reset
//   run             : top is in RUN this cycle (counter active)
//   ce_en           : ce may be asserted next cycle
//   load            : reload counter with min(phase, effective div)
//   wr_en/wr_div/wr_phase : accepted configuration write for this channel
//   ce              : one-cycle clock enable
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DIV_INIT = 0
) (
  input  logic             refclk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             ce_en,
  input  logic             load,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             ce
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] phase_sel;

  // Divider to use at the next boundary: a pending value wins over active.
  assign div_eff   = pend_q ? pend_div_q : div_q;
  // A write landing with a load is seen by the load.
  assign phase_sel = wr_en ? wr_phase : phase_q;

  // Counter, divider handover and config capture.
  always_comb begin
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;

    if (load) begin
      div_d  = div_eff;
      pend_d = 1'b0;
      cnt_d  = DIV_W'(clamp(CLAMP_W'(phase_sel), CLAMP_W'(div_eff)));
    end else if (run) begin
      if (cnt_q == '0) begin
        // Period boundary: the only point a new divider may take effect.
        div_d  = div_eff;
        pend_d = 1'b0;
        cnt_d  = div_eff;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end else if (pend_q) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end

    // New write always ends up pending, overwriting any older pending value.
    if (wr_en) begin
      phase_d    = wr_phase;
      pend_div_d = wr_div;
      pend_d     = 1'b1;
    end

    // ce is high exactly in the cycles where the counter sits at zero.
    ce_d = ce_en && (cnt_d == '0);
  end

  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      div_q      <= DIV_W'(DIV_INIT);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      phase_q    <= '0;
      cnt_q      <= '0;
      ce_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      ce_q       <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: waits for PLL lock, holds a settle
// window, then runs NUM_CH phase-aligned programmable enables.
//   refclk, reset_n        : PLL output clock, synchronous active-low reset
//   pll_locked             : asynchronous lock, synchronised here
//   resync                 : realign all channels to their programmed phases
//   cfg_valid/ready/chan/div/phase : channel configuration write port
//   ce                     : per-channel one-cycle enables
//   running                : high while in RUN
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned DIV_W      = 16,
  parameter  int unsigned SETTLE_CYC = 1024,
  parameter  int unsigned DIV_INIT   = 0,
  localparam int unsigned CH_W       = ch_w(NUM_CH)
) (
  input  logic              refclk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              resync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] ce,
  output logic              running
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e           state_q, state_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_sync_q, lock_sync_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             resync_q, resync_d;
  logic             running_q, running_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             load_c;
  logic             ce_en_c;
  logic             run_c;
  logic [NUM_CH-1:0] wr_en_c;

  // State register.
  always_ff @(posedge refclk) begin
    if (!reset_n) state_q <= WAIT_LOCK;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lock_sync_q) state_d = SETTLE;
      SETTLE: begin
        if (!lock_sync_q)                               state_d = WAIT_LOCK;
        else if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = RUN;
      end
      RUN:       if (!lock_sync_q) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  // FSM outputs and sequencing controls.
  always_comb begin
    settle_d    = '0;
    running_d   = (state_d == RUN);
    run_c       = (state_q == RUN);
    lock_meta_d = pll_locked;
    lock_sync_d = lock_meta_q;
    cfg_ready_d = 1'b1;
    if ((state_q == SETTLE) && (state_d == SETTLE)) settle_d = settle_q + SET_W'(1);
    // Resync is only honoured while RUN continues; it blanks ce for a cycle
    // and the counters reload on the cycle after.
    resync_d = resync && (state_q == RUN) && (state_d == RUN);
    load_c   = (state_d == RUN) && ((state_q == SETTLE) || resync_q);
    ce_en_c  = (state_d == RUN) && !resync_d;
  end

  // Config decode; out-of-range channels match nothing and are dropped.
  always_comb begin
    wr_en_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      wr_en_c[i] = cfg_valid && cfg_ready_q && (cfg_chan == CH_W'(i));
    end
  end

  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      settle_q    <= '0;
      resync_q    <= 1'b0;
      running_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      settle_q    <= settle_d;
      resync_q    <= resync_d;
      running_q   <= running_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_chan
    clk_en_chan #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .refclk   (refclk),
      .reset_n  (reset_n),
      .run      (run_c),
      .ce_en    (ce_en_c),
      .load     (load_c),
      .wr_en    (wr_en_c[g]),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .ce       (ce[g])
    );
  end

  assign running   = running_q;
  assign cfg_ready = cfg_ready_q;

endmodule
